// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter. Words queue in a circular FIFO and are serialised as
// start / data (LSB first) / optional parity / 1-2 stop bits; queued frames chain back-to-back.
module uart_tx_buffered #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int BAUD_DIV_W = 16
) (
  input  logic                        CLK,
  input  logic                        reset,
  input  logic [BAUD_DIV_W-1:0]       baud_div,
  input  logic                        parity_en,
  input  logic                        parity_odd,
  input  logic                        two_stop,
  input  logic                        wr_en,
  input  logic [DATA_BITS-1:0]        wr_data,
  input  logic                        ovf_clr,
  output logic                        Tx,
  output logic                        tx_busy,
  output logic                        done,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BIT_W = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     count_q;
  logic                 ovf_q;
  logic                 fifo_full, fifo_empty;
  logic                 push, pop, ovf_set;
  logic [DATA_BITS-1:0] head;

  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign head       = mem_q[rd_ptr_q];
  // A pop in the same cycle frees a slot, so a write to a full FIFO still lands.
  assign push       = wr_en && (!fifo_full || pop);
  assign ovf_set    = wr_en && fifo_full && !pop;

  // NOTE: the storage array has no reset; only pointers and count define validity,
  // which keeps it mappable onto plain RAM or reset-less flops.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // NOTE: every clocked process uses non-blocking assignments so all registers
  // sample the same pre-edge values regardless of process evaluation order.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (ovf_set)      ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  state_e                state_q, state_d;
  logic [BAUD_DIV_W-1:0] cnt_q, cnt_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic [BAUD_DIV_W-1:0] div_q, div_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  two_stop_q, two_stop_d;
  logic                  tx_q, tx_d;
  logic                  done_q, done_d;
  logic                  bit_end;

  assign bit_end = (cnt_q == '0);

  // NOTE: every signal driven here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    div_d      = div_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    two_stop_d = two_stop_q;
    done_d     = 1'b0;
    pop        = 1'b0;

    case (state_q)
      S_IDLE: begin
        pop = !fifo_empty;
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          cnt_d   = div_q;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q - BAUD_DIV_W'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d   = div_q;
          shift_d = shift_q >> 1;
          if (bit_q == BIT_W'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = par_en_q ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          cnt_d = cnt_q - BAUD_DIV_W'(1);
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          cnt_d   = div_q;
          bit_d   = '0;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q - BAUD_DIV_W'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (two_stop_q && bit_q == '0) begin
            bit_d = BIT_W'(1);
            cnt_d = div_q;
          end else begin
            done_d  = 1'b1;
            pop     = !fifo_empty;
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - BAUD_DIV_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Configuration is captured only here, so mid-frame input changes affect the next frame.
    if (pop) begin
      state_d    = S_START;
      cnt_d      = baud_div;
      bit_d      = '0;
      shift_d    = head;
      div_d      = baud_div;
      par_en_d   = parity_en;
      par_bit_d  = (^head) ^ parity_odd;
      two_stop_d = two_stop;
    end
  end

  // Line level for the state being entered, so Tx is a pure register output.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_bit_q;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      div_q      <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      div_q      <= div_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      two_stop_q <= two_stop_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

  assign Tx         = tx_q;
  assign done       = done_q;
  assign full       = fifo_full;
  assign empty      = fifo_empty;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;
  assign tx_busy    = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: directed scenarios plus randomized traffic, checked against
// a queue-based model that expands each popped word into its per-clock line levels.
module tb_uart_tx_buffered;

  localparam int DATA_BITS  = 8;
  localparam int FIFO_DEPTH = 8;
  localparam int BAUD_DIV_W = 16;
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;
  localparam int ST_W       = 6 + CNT_W;

  logic                  CLK        = 1'b0;
  logic                  reset      = 1'b0;
  logic [BAUD_DIV_W-1:0] baud_div   = '0;
  logic                  parity_en  = 1'b0;
  logic                  parity_odd = 1'b0;
  logic                  two_stop   = 1'b0;
  logic                  wr_en      = 1'b0;
  logic [DATA_BITS-1:0]  wr_data    = '0;
  logic                  ovf_clr    = 1'b0;
  logic                  Tx, tx_busy, done, full, empty, overflow;
  logic [CNT_W-1:0]      fifo_count;
  logic [ST_W-1:0]       dut_status;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  uart_tx_buffered #(
    .DATA_BITS (DATA_BITS),
    .FIFO_DEPTH(FIFO_DEPTH),
    .BAUD_DIV_W(BAUD_DIV_W)
  ) dut (
    .CLK       (CLK),
    .reset     (reset),
    .baud_div  (baud_div),
    .parity_en (parity_en),
    .parity_odd(parity_odd),
    .two_stop  (two_stop),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .ovf_clr   (ovf_clr),
    .Tx        (Tx),
    .tx_busy   (tx_busy),
    .done      (done),
    .full      (full),
    .empty     (empty),
    .fifo_count(fifo_count),
    .overflow  (overflow)
  );

  assign dut_status = {Tx, done, tx_busy, full, empty, fifo_count, overflow};

  // ---------------------------------------------------------------------------
  // Reference model: FIFO as a queue, the current frame as a queue of line levels
  // (one entry per clock). A frame ends when its last level has been shown.
  // ---------------------------------------------------------------------------
  logic [DATA_BITS-1:0] m_fifo[$];
  bit                   m_lv[$];
  logic                 m_tx   = 1'b1;
  logic                 m_done = 1'b0;
  logic                 m_ovf  = 1'b0;
  int                   m_sz;
  int                   m_per;
  bit                   m_pop;
  bit                   m_drop;
  bit                   m_bit;
  logic [DATA_BITS-1:0] m_word;

  always @(posedge CLK or negedge reset) begin
    if (!reset) begin
      m_fifo.delete();
      m_lv.delete();
      m_tx   = 1'b1;
      m_done = 1'b0;
      m_ovf  = 1'b0;
    end else begin
      m_sz   = m_fifo.size();
      m_done = 1'b0;
      m_pop  = 1'b0;
      m_drop = 1'b0;
      if (m_lv.size() == 0) begin
        m_pop = (m_sz != 0);
      end else begin
        m_bit = m_lv.pop_front();
        if (m_lv.size() == 0) begin
          m_done = 1'b1;
          m_pop  = (m_sz != 0);
        end
      end
      if (m_pop) begin
        m_word = m_fifo.pop_front();
        m_per  = int'(baud_div) + 1;
        for (int r = 0; r < m_per; r++) m_lv.push_back(1'b0);
        for (int i = 0; i < DATA_BITS; i++)
          for (int r = 0; r < m_per; r++) m_lv.push_back(m_word[i]);
        if (parity_en)
          for (int r = 0; r < m_per; r++) m_lv.push_back((^m_word) ^ parity_odd);
        for (int r = 0; r < m_per * (two_stop ? 2 : 1); r++) m_lv.push_back(1'b1);
      end
      if (wr_en) begin
        if (m_sz < FIFO_DEPTH || m_pop) m_fifo.push_back(wr_data);
        else m_drop = 1'b1;
      end
      if (m_drop)       m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
      m_tx = (m_lv.size() != 0) ? m_lv[0] : 1'b1;
    end
  end

  function automatic logic [ST_W-1:0] model_status();
    int sz;
    sz = m_fifo.size();
    return {m_tx, m_done, (m_lv.size() != 0) || (sz != 0), sz == FIFO_DEPTH, sz == 0,
            CNT_W'(sz), m_ovf};
  endfunction

  // ---------------------------------------------------------------------------
  // Scenarios (all start and end at a falling edge)
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [ST_W-1:0] exp_rst;
    exp_rst = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, CNT_W'(0), 1'b0};
    reset = 1'b0;
    repeat (2) @(negedge CLK);
    n_cmp++;
    if (dut_status !== exp_rst) begin
      n_bad++;
      $display("FAIL reset_held: status got %b want %b", dut_status, exp_rst);
    end
    reset = 1'b1;
    repeat (2) @(negedge CLK);
    n_cmp++;
    if (dut_status !== exp_rst) begin
      n_bad++;
      $display("FAIL reset_released: status got %b want %b", dut_status, exp_rst);
    end
  endtask

  task automatic test_single_frame();
    logic [7:0] w;
    logic       exp_tx;
    int         done_at;
    w = 8'hA5;
    done_at = -1;
    baud_div = 3; parity_en = 0; parity_odd = 0; two_stop = 0;
    wr_en = 1; wr_data = w;
    @(negedge CLK);
    wr_en = 0;
    n_cmp++;
    if (Tx !== 1'b1 || empty !== 1'b0) begin
      n_bad++;
      $display("FAIL single_after_write: Tx/empty got %b%b want 10", Tx, empty);
    end
    for (int k = 1; k <= 60; k++) begin
      @(negedge CLK);
      if (k <= 4)       exp_tx = 1'b0;
      else if (k <= 36) exp_tx = w[(k - 5) / 4];
      else              exp_tx = 1'b1;
      n_cmp++;
      if (Tx !== exp_tx) begin
        n_bad++;
        $display("FAIL single_bits k=%0d: Tx got %b want %b", k, Tx, exp_tx);
      end
      n_cmp++;
      if (dut_status !== model_status()) begin
        n_bad++;
        $display("FAIL single_model k=%0d: status got %b want %b", k, dut_status, model_status());
      end
      if (done === 1'b1 && done_at < 0) done_at = k;
    end
    n_cmp++;
    if (done_at !== 41) begin
      n_bad++;
      $display("FAIL single_done_time: got %0d want 41", done_at);
    end
  endtask

  task automatic test_parity_stop();
    logic hist[64];
    int   done_at, stop_len;
    logic exp_par;
    for (int c = 0; c < 3; c++) begin
      baud_div   = 3;
      parity_en  = 1;
      parity_odd = (c == 1);
      two_stop   = (c == 2);
      exp_par    = parity_odd ? 1'b0 : 1'b1;
      done_at    = -1;
      wr_en = 1; wr_data = 8'h07;
      @(negedge CLK);
      wr_en = 0;
      hist[0] = Tx;
      for (int k = 1; k < 64; k++) begin
        @(negedge CLK);
        hist[k] = Tx;
        n_cmp++;
        if (dut_status !== model_status()) begin
          n_bad++;
          $display("FAIL parity_model cfg=%0d k=%0d: status got %b want %b", c, k, dut_status,
                   model_status());
        end
        if (done === 1'b1 && done_at < 0) done_at = k;
      end
      n_cmp++;
      if (hist[38] !== exp_par) begin
        n_bad++;
        $display("FAIL parity_bit cfg=%0d: got %b want %b", c, hist[38], exp_par);
      end
      n_cmp++;
      if (done_at !== 1 + 4 * (11 + int'(two_stop))) begin
        n_bad++;
        $display("FAIL parity_done_time cfg=%0d: got %0d want %0d", c, done_at,
                 1 + 4 * (11 + int'(two_stop)));
      end
      stop_len = 0;
      for (int k = 41; k < 64 && hist[k] === 1'b1 && k < done_at; k++) stop_len++;
      n_cmp++;
      if (stop_len !== 4 * (1 + int'(two_stop))) begin
        n_bad++;
        $display("FAIL stop_length cfg=%0d: got %0d want %0d", c, stop_len,
                 4 * (1 + int'(two_stop)));
      end
    end
    parity_en = 0; parity_odd = 0; two_stop = 0;
  endtask

  task automatic test_cfg_change();
    int d0, d1;
    d0 = -1; d1 = -1;
    baud_div = 3; parity_en = 0; two_stop = 0;
    wr_en = 1; wr_data = 8'h3C;
    @(negedge CLK);
    wr_data = 8'hC3;
    @(negedge CLK);
    wr_en = 0;
    for (int k = 2; k <= 90; k++) begin
      @(negedge CLK);
      if (k == 10) baud_div = 1;
      n_cmp++;
      if (dut_status !== model_status()) begin
        n_bad++;
        $display("FAIL cfg_model k=%0d: status got %b want %b", k, dut_status, model_status());
      end
      if (done === 1'b1) begin
        if (d0 < 0) d0 = k;
        else if (d1 < 0) d1 = k;
      end
    end
    n_cmp++;
    if (d0 !== 41 || d1 !== 61) begin
      n_bad++;
      $display("FAIL cfg_done_times: got %0d,%0d want 41,61", d0, d1);
    end
    baud_div = 3;
  endtask

  task automatic test_burst();
    int ndone, last;
    ndone = 0; last = -1;
    baud_div = 1; parity_en = 0; two_stop = 0;
    wr_en = 1;
    for (int i = 0; i <= FIFO_DEPTH; i++) begin
      wr_data = DATA_BITS'($urandom);
      @(negedge CLK);
    end
    wr_en = 0;
    n_cmp++;
    if (full !== 1'b1) begin
      n_bad++;
      $display("FAIL burst_full: got %b want 1", full);
    end
    for (int k = FIFO_DEPTH + 1; k <= (FIFO_DEPTH + 3) * 20; k++) begin
      @(negedge CLK);
      n_cmp++;
      if (dut_status !== model_status()) begin
        n_bad++;
        $display("FAIL burst_model k=%0d: status got %b want %b", k, dut_status, model_status());
      end
      if (done === 1'b1) begin
        if (last >= 0) begin
          n_cmp++;
          if (k - last !== 20) begin
            n_bad++;
            $display("FAIL burst_gap: got %0d want 20", k - last);
          end
        end
        last = k;
        ndone++;
      end
    end
    n_cmp++;
    if (ndone !== FIFO_DEPTH + 1) begin
      n_bad++;
      $display("FAIL burst_done_count: got %0d want %0d", ndone, FIFO_DEPTH + 1);
    end
    n_cmp++;
    if (empty !== 1'b1 || tx_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL burst_end: empty/tx_busy got %b%b want 10", empty, tx_busy);
    end
  endtask

  task automatic test_overflow();
    int k;
    baud_div = 3; parity_en = 0; two_stop = 0;
    wr_en = 1; wr_data = DATA_BITS'($urandom);
    @(negedge CLK);
    k = 0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      wr_data = DATA_BITS'($urandom);
      @(negedge CLK);
      k++;
    end
    wr_data = DATA_BITS'($urandom);
    @(negedge CLK);
    k++;
    wr_en = 0;
    n_cmp++;
    if (overflow !== 1'b1 || fifo_count !== CNT_W'(FIFO_DEPTH)) begin
      n_bad++;
      $display("FAIL ovf_drop: overflow/count got %b/%0d want 1/%0d", overflow, fifo_count,
               FIFO_DEPTH);
    end
    ovf_clr = 1;
    @(negedge CLK);
    k++;
    ovf_clr = 0;
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL ovf_clear: got %b want 0", overflow);
    end
    wr_en = 1; ovf_clr = 1;
    @(negedge CLK);
    k++;
    wr_en = 0; ovf_clr = 0;
    n_cmp++;
    if (overflow !== 1'b1 || fifo_count !== CNT_W'(FIFO_DEPTH)) begin
      n_bad++;
      $display("FAIL ovf_set_wins: overflow/count got %b/%0d want 1/%0d", overflow, fifo_count,
               FIFO_DEPTH);
    end
    ovf_clr = 1;
    @(negedge CLK);
    k++;
    ovf_clr = 0;
    while (k < 40) begin
      @(negedge CLK);
      k++;
    end
    wr_en = 1; wr_data = DATA_BITS'($urandom);
    @(negedge CLK);
    wr_en = 0;
    n_cmp++;
    if (done !== 1'b1 || fifo_count !== CNT_W'(FIFO_DEPTH) || overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL ovf_push_with_pop: done/count/overflow got %b/%0d/%b want 1/%0d/0", done,
               fifo_count, overflow, FIFO_DEPTH);
    end
    for (int j = 0; j < (FIFO_DEPTH + 1) * 40 + 10; j++) begin
      @(negedge CLK);
      n_cmp++;
      if (dut_status !== model_status()) begin
        n_bad++;
        $display("FAIL ovf_drain j=%0d: status got %b want %b", j, dut_status, model_status());
      end
    end
  endtask

  task automatic test_reset_midframe();
    baud_div = 3; parity_en = 0; two_stop = 0;
    wr_en = 1;
    for (int i = 0; i < 4; i++) begin
      wr_data = DATA_BITS'($urandom);
      @(negedge CLK);
    end
    wr_en = 0;
    repeat (7) @(negedge CLK);
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if (Tx !== 1'b1 || fifo_count !== CNT_W'(0)) begin
      n_bad++;
      $display("FAIL reset_async: Tx/count got %b/%0d want 1/0", Tx, fifo_count);
    end
    @(negedge CLK);
    reset = 1'b1;
    n_cmp++;
    if (empty !== 1'b1 || fifo_count !== CNT_W'(0)) begin
      n_bad++;
      $display("FAIL reset_fifo: empty/count got %b/%0d want 1/0", empty, fifo_count);
    end
    for (int k = 0; k < 100; k++) begin
      @(negedge CLK);
      n_cmp++;
      if (Tx !== 1'b1 || done !== 1'b0 || tx_busy !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_quiet k=%0d: Tx/done/busy got %b%b%b want 100", k, Tx, done, tx_busy);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      baud_div   = BAUD_DIV_W'($urandom_range(0, 2));
      parity_en  = 1'($urandom);
      parity_odd = 1'($urandom);
      two_stop   = 1'($urandom);
      wr_en      = (k < 1000) && ($urandom_range(0, 3) == 0);
      wr_data    = DATA_BITS'($urandom);
      ovf_clr    = ($urandom_range(0, 15) == 0);
      @(negedge CLK);
      n_cmp++;
      if (dut_status !== model_status()) begin
        n_bad++;
        $display("FAIL random k=%0d: status got %b want %b", k, dut_status, model_status());
      end
    end
    wr_en = 0; ovf_clr = 0;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_parity_stop();
    test_cfg_change();
    test_burst();
    test_overflow();
    test_reset_midframe();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
